// File: rtl/seq_accumulator.sv
// seq_accumulator
//   Sums N_SAMPLES signed operands from a valid/ready input stream with a
//   single combinational adder. The total is then offered on a valid/ready
//   output stream, together with a sticky signed-overflow flag.
//
//   Build option: define SEQ_ACC_SATURATE_EN to clamp the accumulator on
//   overflow. When the macro is undefined, the accumulator wraps and only
//   out_ovf reports the overflow.
//
//   ARCH_TYPE selects the adder implementation:
//     0 = plain '+' (the synthesizer picks the structure)
//     1 = explicit ripple-carry chain

module seq_accumulator #(
   parameter int parallelism = 32,
   parameter int N_SAMPLES   = 8,
   parameter int ARCH_TYPE   = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [parallelism-1:0] in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [parallelism-1:0] out_data,
   output logic                   out_ovf
);

   localparam int MSB   = parallelism - 1;
   localparam int CNT_W = $clog2(N_SAMPLES + 1);
   // The counter value seen on the cycle that accepts the final operand.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic [parallelism-1:0] acc;
   logic [parallelism-1:0] acc_next;
   logic [parallelism-1:0] add_a;
   logic [parallelism-1:0] add_sum;
   logic [CNT_W-1:0]       cnt;
   logic                   ovf;
   logic                   ovf_det;
   logic                   accept;
   logic                   xfer;
   logic                   last;

   assign accept = in_valid & in_ready;
   assign xfer   = out_valid & out_ready;
   assign last   = (cnt == LAST_CNT);

   // In IDLE the first operand is added to zero. This loads the accumulator
   // through the same adder that is used for every later operand.
   assign add_a = (state == ACCUM) ? acc : '0;

   // Adder core. The carry-in is tied to zero in both implementations.
   generate
      if (ARCH_TYPE == 1) begin : g_ripple
         // Explicit ripple-carry chain, one full adder per bit.
         always_comb begin
            logic carry;
            carry   = 1'b0;
            add_sum = '0;
            for (int i = 0; i < parallelism; i++) begin
               add_sum[i] = add_a[i] ^ in_data[i] ^ carry;
               carry      = (add_a[i] & in_data[i]) | (carry & (add_a[i] ^ in_data[i]));
            end
         end
      end else begin : g_behav
         assign add_sum = add_a + in_data;
      end
   endgenerate

   // Signed overflow: both addends have the same sign, but the sum's sign differs.
   assign ovf_det = (add_a[MSB] == in_data[MSB]) && (add_sum[MSB] != add_a[MSB]);

`ifdef SEQ_ACC_SATURATE_EN
   localparam logic [parallelism-1:0] SAT_MAX = {1'b0, {MSB{1'b1}}};
   localparam logic [parallelism-1:0] SAT_MIN = {1'b1, {MSB{1'b0}}};

   // Clamp toward the sign shared by both addends whenever the sum wraps.
   always_comb begin
      acc_next = add_sum;
      if (ovf_det) begin
         acc_next = add_a[MSB] ? SAT_MIN : SAT_MAX;
      end
   end
`else
   assign acc_next = add_sum;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: registers use non-blocking assignments so that every flop samples pre-edge values.
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. clear wins over any handshake in the same cycle.
   always_comb begin
      // NOTE: assigning a default first keeps every path assigned, so no latch is inferred.
      state_next = state;
      if (clear) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (accept) state_next = (N_SAMPLES == 1) ? DONE : ACCUM;
            ACCUM:   if (accept && last) state_next = DONE;
            DONE:    if (xfer) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Output decode. in_ready depends only on state and rst, never on in_valid.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      out_ovf   = 1'b0;
      case (state)
         IDLE, ACCUM: in_ready = ~rst;
         DONE: begin
            out_valid = 1'b1;
            out_data  = acc;
            out_ovf   = ovf;
         end
         default: ;
      endcase
   end

   // Accumulator, sample counter and sticky overflow flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (clear) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (accept) begin
         acc <= acc_next;
         if (state == IDLE) begin
            cnt <= CNT_W'(1);
            ovf <= 1'b0;
         end else begin
            cnt <= cnt + CNT_W'(1);
            ovf <= ovf | ovf_det;
         end
      end else if (xfer) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seq_accumulator.sv
// tb_seq_accumulator
//   Four seq_accumulator instances share one set of stimulus inputs.
//   Each has a different width, sample count and adder architecture.
//   A selector picks the instance under test. An integer-range reference
//   model pushes the expected results into a queue, and a monitor pops and
//   compares each result when it is transferred.

module tb_seq_accumulator;

   typedef struct {
      longint data;
      logic   ovf;
   } result_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_ready;

   logic        ready_a, valid_a, ovf_a;
   logic [31:0] data_a;
   logic        ready_b, valid_b, ovf_b;
   logic [7:0]  data_b;
   logic        ready_c, valid_c, ovf_c;
   logic [31:0] data_c;
   logic        ready_d, valid_d, ovf_d;
   logic [15:0] data_d;

   logic        mon_ready, mon_valid, mon_ovf;
   longint      mon_data;

   int          n_checks = 0;
   int          n_errors = 0;
   result_t     sb_q[$];
   result_t     exp_r;

   int          sel = 0;
   int          ready_mode = 0;   // 0 = ready high, 1 = ready low, 2 = random
   int          m_w = 32;
   int          m_n = 8;
   int          m_cnt = 0;
   longint      m_acc = 0;
   logic        m_ovf = 1'b0;

   int          cfg_w [4] = '{32, 8, 32, 16};
   int          cfg_n [4] = '{8, 2, 4, 1};
   int          t4_ops [12] = '{100, 100, -100, -100, 127, 1, -128, -1, 50, -100, 1, 2};

   always #5 clk = ~clk;

   seq_accumulator #(.parallelism(32), .N_SAMPLES(8), .ARCH_TYPE(0)) dut_a (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(ready_a),
      .in_data(in_data), .out_valid(valid_a), .out_ready(out_ready),
      .out_data(data_a), .out_ovf(ovf_a));

   seq_accumulator #(.parallelism(8), .N_SAMPLES(2), .ARCH_TYPE(1)) dut_b (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(ready_b),
      .in_data(in_data[7:0]), .out_valid(valid_b), .out_ready(out_ready),
      .out_data(data_b), .out_ovf(ovf_b));

   seq_accumulator #(.parallelism(32), .N_SAMPLES(4), .ARCH_TYPE(1)) dut_c (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(ready_c),
      .in_data(in_data), .out_valid(valid_c), .out_ready(out_ready),
      .out_data(data_c), .out_ovf(ovf_c));

   seq_accumulator #(.parallelism(16), .N_SAMPLES(1), .ARCH_TYPE(0)) dut_d (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(ready_d),
      .in_data(in_data[15:0]), .out_valid(valid_d), .out_ready(out_ready),
      .out_data(data_d), .out_ovf(ovf_d));

   // Route the selected instance's outputs to the monitor, sign-extended to 64 bits.
   always_comb begin
      mon_ready = ready_a;
      mon_valid = valid_a;
      mon_data  = longint'($signed(data_a));
      mon_ovf   = ovf_a;
      case (sel)
         1: begin mon_ready = ready_b; mon_valid = valid_b; mon_data = longint'($signed(data_b)); mon_ovf = ovf_b; end
         2: begin mon_ready = ready_c; mon_valid = valid_c; mon_data = longint'($signed(data_c)); mon_ovf = ovf_c; end
         3: begin mon_ready = ready_d; mon_valid = valid_d; mon_data = longint'($signed(data_d)); mon_ovf = ovf_d; end
         default: ;
      endcase
   end

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reduce v to a signed w-bit two's-complement value.
   function automatic longint wrap(input longint v, input int w);
      longint m;
      longint r;
      m = longint'(1) << w;
      r = v & (m - 1);
      if (r >= (m >> 1)) r = r - m;
      return r;
   endfunction

   task automatic model_reset();
      m_acc = 0;
      m_cnt = 0;
      m_ovf = 1'b0;
   endtask

   // Reference model: exact integer sum, then a range test for overflow.
   task automatic model_accept(input logic [31:0] d);
      longint op, s, mx, mn;
      result_t r;
      op = wrap(longint'(d), m_w);
      mx = (longint'(1) << (m_w - 1)) - 1;
      mn = -mx - 1;
      s  = m_acc + op;
      if (s > mx || s < mn) begin
         m_ovf = 1'b1;
`ifdef SEQ_ACC_SATURATE_EN
         m_acc = (s > mx) ? mx : mn;
`else
         m_acc = wrap(s, m_w);
`endif
      end else begin
         m_acc = s;
      end
      m_cnt++;
      if (m_cnt == m_n) begin
         r.data = m_acc;
         r.ovf  = m_ovf;
         sb_q.push_back(r);
         model_reset();
      end
   endtask

   // out_ready driver. It updates 2 time units after each rising edge.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Scoreboard monitor: compare each transferred result with the oldest expected one.
   always @(negedge clk) begin
      if (!rst && mon_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            check("unexpected_result", mon_valid, 0);
         end else begin
            exp_r = sb_q.pop_front();
            check("result_data", mon_data, exp_r.data);
            check("result_ovf", mon_ovf, exp_r.ovf);
         end
      end
   end

   // Offer one operand and wait, with a bound, for it to be accepted.
   // Entered and exited 1 time unit after a rising edge.
   task automatic send(input logic [31:0] d);
      int waited;
      waited   = 0;
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      while (!mon_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!mon_ready) begin
         check("send_in_ready", mon_ready, 1);
         @(posedge clk);
         #1;
      end else begin
         @(posedge clk);
         model_accept(d);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int waited;
      waited     = 0;
      ready_mode = 0;
      while (sb_q.size() != 0 && waited < 200) begin
         @(posedge clk);
         waited++;
      end
      @(posedge clk);
      #1;
      check("drain_pending", sb_q.size(), 0);
   endtask

   task automatic do_reset(input int s);
      rst      = 1'b1;
      clear    = 1'b0;
      in_valid = 1'b0;
      #3;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sel = s;
      m_w = cfg_w[s];
      m_n = cfg_n[s];
      model_reset();
      sb_q.delete();
   endtask

   task automatic random_gap();
      repeat ($urandom_range(0, 2)) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst        = 1'b1;
      clear      = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      repeat (2) @(posedge clk);
      #1;

      // T1: asynchronous reset in the middle of ACCUM, after three operands.
      do_reset(0);
      send(32'd11);
      send(32'd12);
      send(32'd13);
      check("t1_accum_ready", mon_ready, 1);
      check("t1_accum_valid", mon_valid, 0);
      #2 rst = 1'b1;
      #1;
      check("t1_rst_in_ready", mon_ready, 0);
      check("t1_rst_out_valid", mon_valid, 0);
      check("t1_rst_out_data", mon_data, 0);
      check("t1_rst_out_ovf", mon_ovf, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      @(negedge clk);
      check("t1_post_in_ready", mon_ready, 1);
      check("t1_post_out_valid", mon_valid, 0);
      check("t1_post_out_data", mon_data, 0);
      check("t1_post_out_ovf", mon_ovf, 0);
      @(posedge clk);
      #1;

      // T2: operands 1..8 sent back to back. The result appears one cycle after the last accept.
      for (int i = 1; i <= 7; i++) send(32'(i));
      check("t2_valid_before_last", mon_valid, 0);
      ready_mode = 1;
      send(32'd8);
      check("t2_valid_latency", mon_valid, 1);
      check("t2_data", mon_data, 36);

      // T3: backpressure with the producer still offering an operand.
      in_valid = 1'b1;
      in_data  = 32'd99;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t3_in_ready", mon_ready, 0);
         check("t3_valid_hold", mon_valid, 1);
         check("t3_data_hold", mon_data, sb_q[0].data);
         check("t3_ovf_hold", mon_ovf, sb_q[0].ovf);
      end
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      ready_mode = 0;
      drain();
      check("t3_back_to_idle", mon_ready, 1);
      for (int i = 0; i < 8; i++) send(32'd10);
      drain();

      // T4: overflow cases on the 8-bit, two-sample instance.
      do_reset(1);
      foreach (t4_ops[i]) send(32'(t4_ops[i]));
      drain();
      ready_mode = 2;
      for (int k = 0; k < 800; k++) begin
         random_gap();
         send($urandom);
      end
      drain();

      // T5: clear drops the operand offered in the same cycle.
      do_reset(2);
      send(32'd5);
      send(32'd6);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'd9;
      @(posedge clk);
      #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      model_reset();
      check("t5_idle_ready", mon_ready, 1);
      check("t5_idle_valid", mon_valid, 0);
      for (int i = 0; i < 4; i++) send(32'd1);
      check("t5_data", mon_data, 4);
      drain();

      // T6: single-sample instance, then 1000 random sums with random gaps and backpressure.
      do_reset(3);
      send(-32'sd7);
      check("t6_valid_latency", mon_valid, 1);
      check("t6_data", mon_data, -7);
      drain();
      ready_mode = 2;
      for (int k = 0; k < 1000; k++) begin
         random_gap();
         send($urandom);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
